// File: rtl/maze_pkg.sv
// Shared constants and encodings for the maze cell RAM arbiter.
package maze_pkg;

  localparam int ADDR_W  = 8;    // {row[3:0], col[3:0]}
  localparam int N_CELLS = 256;  // cells swept by a clear, 2**ADDR_W

  typedef enum logic {
    SERVE = 1'b0,
    CLEAR = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    LOADER  = 2'd0,
    SOLVER  = 2'd1,
    DISPLAY = 2'd2
  } req_id_t;

endpackage

// File: rtl/maze_mem_arbiter_if.sv
// Requester, clear-control and RAM-side signals of the maze cell RAM arbiter.
// The arbiter takes the slave view; requesters and the RAM wrapper take master.
interface maze_mem_arbiter_if;
  import maze_pkg::*;

  // clear sweep control
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;

  // loader port
  logic              ld_req;
  logic              ld_wr;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_din;
  logic              ld_gnt;
  logic              ld_dout;
  logic              ld_valid;

  // solver port
  logic              sv_req;
  logic              sv_wr;
  logic [ADDR_W-1:0] sv_addr;
  logic              sv_din;
  logic              sv_gnt;
  logic              sv_dout;
  logic              sv_valid;

  // display port (read-only)
  logic              dp_req;
  logic [ADDR_W-1:0] dp_addr;
  logic              dp_gnt;
  logic              dp_dout;
  logic              dp_valid;

  // RAM wrapper
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_din;
  logic              mem_dout;

  modport slave (
    input  clr_req,
    output clr_busy, clr_done,
    input  ld_req, ld_wr, ld_addr, ld_din,
    output ld_gnt, ld_dout, ld_valid,
    input  sv_req, sv_wr, sv_addr, sv_din,
    output sv_gnt, sv_dout, sv_valid,
    input  dp_req, dp_addr,
    output dp_gnt, dp_dout, dp_valid,
    output mem_en, mem_we, mem_addr, mem_din,
    input  mem_dout
  );

  modport master (
    output clr_req,
    input  clr_busy, clr_done,
    output ld_req, ld_wr, ld_addr, ld_din,
    input  ld_gnt, ld_dout, ld_valid,
    output sv_req, sv_wr, sv_addr, sv_din,
    input  sv_gnt, sv_dout, sv_valid,
    output dp_req, dp_addr,
    input  dp_gnt, dp_dout, dp_valid,
    input  mem_en, mem_we, mem_addr, mem_din,
    output mem_dout
  );

endinterface

// File: rtl/maze_rr_arb2.sv
// Two-way round-robin between solver and display. On a tie the port that
// was not granted last wins; the history only moves when one of them is granted.
module maze_rr_arb2
  import maze_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sv_req,   // already qualified by loader priority and FSM state
  input  logic dp_req,
  output logic sv_gnt,
  output logic dp_gnt
);

  req_id_t rr_last;

  // Combinational grant so the access is issued in the request cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sv_gnt = 1'b0;
    dp_gnt = 1'b0;
    if (sv_req && dp_req) begin
      if (rr_last == DISPLAY) sv_gnt = 1'b1;
      else                    dp_gnt = 1'b1;
    end else begin
      sv_gnt = sv_req;
      dp_gnt = dp_req;
    end
  end

  // Remember the last winner; reset favours the solver on the first tie.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst)         rr_last <= DISPLAY;
    else if (sv_gnt) rr_last <= SOLVER;
    else if (dp_gnt) rr_last <= DISPLAY;
  end

endmodule

// File: rtl/maze_mem_arbiter.sv
// Shares the single-port maze cell RAM between loader, solver and display,
// and runs a self-sequenced sweep that zeroes every cell before a new solve.
// Loader has absolute priority; solver and display round-robin between them.
module maze_mem_arbiter
  import maze_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  maze_mem_arbiter_if.slave  bus
);

  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(N_CELLS - 1);

  state_t            state;
  logic [ADDR_W:0]   clr_cnt;   // one spare bit so the terminal compare cannot wrap
  logic              clr_done_q;

  logic              serve_ok;
  logic              ld_gnt;
  logic              sv_gnt;
  logic              dp_gnt;

  logic              ld_pend, sv_pend, dp_pend;
  logic              ld_hold, sv_hold, dp_hold;

  // Grants are only possible in SERVE, out of reset, and not while a clear is being requested.
  assign serve_ok = !rst && (state == SERVE) && !bus.clr_req;
  assign ld_gnt   = serve_ok && bus.ld_req;

  maze_rr_arb2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .sv_req (serve_ok && !bus.ld_req && bus.sv_req),
    .dp_req (serve_ok && !bus.ld_req && bus.dp_req),
    .sv_gnt (sv_gnt),
    .dp_gnt (dp_gnt)
  );

  // Sequence the clear sweep and flag its completion for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SERVE;
      clr_cnt    <= '0;
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      case (state)
        SERVE: if (bus.clr_req) state <= CLEAR;
        CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            state      <= SERVE;
            clr_cnt    <= '0;
            clr_done_q <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= SERVE;
      endcase
    end
  end

  // Drive the RAM from the sweep counter or from the winning requester.
  always_comb begin
    bus.mem_en   = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
    bus.mem_din  = 1'b0;
    if (!rst) begin
      if (state == CLEAR) begin
        bus.mem_en   = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = clr_cnt[ADDR_W-1:0];
      end else if (ld_gnt) begin
        bus.mem_en   = 1'b1;
        bus.mem_we   = bus.ld_wr;
        bus.mem_addr = bus.ld_addr;
        bus.mem_din  = bus.ld_din;
      end else if (sv_gnt) begin
        bus.mem_en   = 1'b1;
        bus.mem_we   = bus.sv_wr;
        bus.mem_addr = bus.sv_addr;
        bus.mem_din  = bus.sv_din;
      end else if (dp_gnt) begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.dp_addr;
      end
    end
  end

  // Track granted reads so data is tagged valid when the RAM returns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_pend <= 1'b0;
      sv_pend <= 1'b0;
      dp_pend <= 1'b0;
    end else begin
      ld_pend <= ld_gnt && !bus.ld_wr;
      sv_pend <= sv_gnt && !bus.sv_wr;
      dp_pend <= dp_gnt;
    end
  end

  // Keep each port's last returned read data between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_hold <= 1'b0;
      sv_hold <= 1'b0;
      dp_hold <= 1'b0;
    end else begin
      if (ld_pend) ld_hold <= bus.mem_dout;
      if (sv_pend) sv_hold <= bus.mem_dout;
      if (dp_pend) dp_hold <= bus.mem_dout;
    end
  end

  assign bus.ld_gnt   = ld_gnt;
  assign bus.sv_gnt   = sv_gnt;
  assign bus.dp_gnt   = dp_gnt;

  assign bus.ld_valid = ld_pend;
  assign bus.sv_valid = sv_pend;
  assign bus.dp_valid = dp_pend;

  assign bus.ld_dout  = ld_pend ? bus.mem_dout : ld_hold;
  assign bus.sv_dout  = sv_pend ? bus.mem_dout : sv_hold;
  assign bus.dp_dout  = dp_pend ? bus.mem_dout : dp_hold;

  assign bus.clr_busy = (state == CLEAR);
  assign bus.clr_done = clr_done_q;

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Directed bench for maze_mem_arbiter with a behavioural 256x1 RAM
// (registered read, one-cycle latency) attached to the memory side.
module tb_maze_mem_arbiter;
  import maze_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  maze_mem_arbiter_if bus ();

  maze_mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model
  logic ram [0:N_CELLS-1];
  logic ram_q;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
      else            ram_q <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_dout = ram_q;

  // Advance one clock; inputs change just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clr_req = 1'b0;
    bus.ld_req = 1'b0; bus.ld_wr = 1'b0; bus.ld_addr = '0; bus.ld_din = 1'b0;
    bus.sv_req = 1'b0; bus.sv_wr = 1'b0; bus.sv_addr = '0; bus.sv_din = 1'b0;
    bus.dp_req = 1'b0; bus.dp_addr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.ld_req = 1'b1;
    bus.sv_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({bus.ld_gnt, bus.sv_gnt, bus.dp_gnt, bus.mem_en, bus.mem_we} !== 5'b0) begin
        bad++;
        $display("FAIL reset_gnt cyc=%0d got ld/sv/dp/en/we=%b exp=00000", i,
                 {bus.ld_gnt, bus.sv_gnt, bus.dp_gnt, bus.mem_en, bus.mem_we});
      end
      cyc();
    end
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    total++;
    if ({bus.ld_gnt, bus.sv_gnt, bus.dp_gnt, bus.mem_en,
         bus.ld_valid, bus.sv_valid, bus.dp_valid, bus.clr_busy, bus.clr_done} !== 9'b0) begin
      bad++;
      $display("FAIL reset_idle got=%b exp=000000000",
               {bus.ld_gnt, bus.sv_gnt, bus.dp_gnt, bus.mem_en,
                bus.ld_valid, bus.sv_valid, bus.dp_valid, bus.clr_busy, bus.clr_done});
    end
    total++;
    if ({bus.ld_dout, bus.sv_dout, bus.dp_dout} !== 3'b0) begin
      bad++;
      $display("FAIL reset_dout got=%b exp=000", {bus.ld_dout, bus.sv_dout, bus.dp_dout});
    end
    cyc();
  endtask

  task automatic test_clear();
    logic [12:0] got;
    logic [12:0] exp;
    ram[5] = 1'b1;
    bus.sv_req  = 1'b1;
    bus.sv_wr   = 1'b0;
    bus.sv_addr = 8'h05;
    bus.clr_req = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.sv_gnt, bus.mem_en} !== 2'b00) begin
      bad++;
      $display("FAIL clr_req_cycle got gnt/en=%b exp=00", {bus.sv_gnt, bus.mem_en});
    end
    cyc();
    for (int i = 0; i < N_CELLS; i++) begin
      bus.clr_req = (i == 50);
      @(negedge clk);
      got = {bus.clr_busy, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din, bus.sv_gnt};
      exp = {1'b1, 1'b1, 1'b1, 8'(i), 1'b0, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL sweep cyc=%0d got busy/en/we/addr/din/gnt=%h exp=%h", i, got, exp);
      end
      cyc();
    end
    bus.clr_req = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.clr_busy, bus.clr_done, bus.sv_gnt} !== 3'b011) begin
      bad++;
      $display("FAIL sweep_end got busy/done/sv_gnt=%b exp=011",
               {bus.clr_busy, bus.clr_done, bus.sv_gnt});
    end
    total++;
    if (bus.mem_addr !== 8'h05) begin
      bad++;
      $display("FAIL sweep_end_addr got=%h exp=05", bus.mem_addr);
    end
    cyc();
    bus.sv_req = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.clr_done, bus.sv_valid, bus.sv_dout, bus.mem_en} !== 4'b0100) begin
      bad++;
      $display("FAIL sweep_after got done/valid/dout/en=%b exp=0100",
               {bus.clr_done, bus.sv_valid, bus.sv_dout, bus.mem_en});
    end
    cyc();
  endtask

  task automatic test_tie_fairness();
    logic exp_sv;
    do_reset();
    bus.sv_req = 1'b1; bus.sv_addr = 8'h10;
    bus.dp_req = 1'b1; bus.dp_addr = 8'h20;
    for (int i = 0; i < 6; i++) begin
      exp_sv = (i % 2 == 0);
      @(negedge clk);
      total++;
      if ({bus.sv_gnt, bus.dp_gnt} !== {exp_sv, !exp_sv}) begin
        bad++;
        $display("FAIL tie cyc=%0d got sv/dp=%b exp=%b", i,
                 {bus.sv_gnt, bus.dp_gnt}, {exp_sv, !exp_sv});
      end
      cyc();
    end
    bus.sv_req = 1'b0;
    bus.dp_req = 1'b0;
    cyc();
  endtask

  task automatic test_loader_priority();
    bus.ld_req = 1'b1; bus.ld_wr = 1'b1; bus.ld_din = 1'b1; bus.ld_addr = 8'h20;
    bus.sv_req = 1'b1; bus.sv_wr = 1'b0; bus.sv_addr = 8'h21;
    bus.dp_req = 1'b1; bus.dp_addr = 8'h22;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({bus.ld_gnt, bus.sv_gnt, bus.dp_gnt, bus.mem_we, bus.mem_din, bus.mem_addr} !==
          {5'b10011, 8'h20}) begin
        bad++;
        $display("FAIL ld_prio cyc=%0d got ld/sv/dp/we/din,addr=%b,%h exp=10011,20", i,
                 {bus.ld_gnt, bus.sv_gnt, bus.dp_gnt, bus.mem_we, bus.mem_din}, bus.mem_addr);
      end
      cyc();
    end
    bus.ld_req = 1'b0;
    bus.ld_wr  = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.ld_gnt, bus.sv_gnt, bus.dp_gnt, bus.mem_we, bus.mem_addr} !== {4'b0100, 8'h21}) begin
      bad++;
      $display("FAIL ld_drop got ld/sv/dp/we,addr=%b,%h exp=0100,21",
               {bus.ld_gnt, bus.sv_gnt, bus.dp_gnt, bus.mem_we}, bus.mem_addr);
    end
    cyc();
    bus.sv_req = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.dp_gnt, bus.sv_valid, bus.sv_dout, bus.mem_we, bus.mem_addr} !== {4'b1100, 8'h22}) begin
      bad++;
      $display("FAIL dp_after_sv got gnt/sv_valid/sv_dout/we,addr=%b,%h exp=1100,22",
               {bus.dp_gnt, bus.sv_valid, bus.sv_dout, bus.mem_we}, bus.mem_addr);
    end
    cyc();
    bus.dp_req = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.dp_valid, bus.dp_dout, ram[8'h20]} !== 3'b101) begin
      bad++;
      $display("FAIL ld_write_dp_read got dp_valid/dp_dout/ram20=%b exp=101",
               {bus.dp_valid, bus.dp_dout, ram[8'h20]});
    end
    cyc();
  endtask

  task automatic test_read_latency();
    ram[8'h3A] = 1'b1;
    bus.sv_req = 1'b1; bus.sv_wr = 1'b0; bus.sv_addr = 8'h3A;
    @(negedge clk);
    total++;
    if ({bus.sv_gnt, bus.sv_valid, bus.mem_en, bus.mem_we} !== 4'b1010) begin
      bad++;
      $display("FAIL rd_gnt got gnt/valid/en/we=%b exp=1010",
               {bus.sv_gnt, bus.sv_valid, bus.mem_en, bus.mem_we});
    end
    cyc();
    bus.sv_req = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.sv_valid, bus.sv_dout} !== 2'b11) begin
      bad++;
      $display("FAIL rd_return got valid/dout=%b exp=11", {bus.sv_valid, bus.sv_dout});
    end
    cyc();
    @(negedge clk);
    total++;
    if ({bus.sv_valid, bus.sv_dout} !== 2'b01) begin
      bad++;
      $display("FAIL rd_hold got valid/dout=%b exp=01", {bus.sv_valid, bus.sv_dout});
    end
    cyc();
    // solver writes 1 into a cell the bench has zeroed, display then reads it
    ram[8'h3A] = 1'b0;
    bus.sv_req = 1'b1; bus.sv_wr = 1'b1; bus.sv_din = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.sv_gnt, bus.mem_we, bus.mem_din, bus.mem_addr} !== {3'b111, 8'h3A}) begin
      bad++;
      $display("FAIL wr_gnt got gnt/we/din,addr=%b,%h exp=111,3a",
               {bus.sv_gnt, bus.mem_we, bus.mem_din}, bus.mem_addr);
    end
    cyc();
    bus.sv_req = 1'b0; bus.sv_wr = 1'b0; bus.sv_din = 1'b0;
    bus.dp_req = 1'b1; bus.dp_addr = 8'h3A;
    @(negedge clk);
    total++;
    if ({bus.sv_valid, bus.dp_gnt, bus.mem_we} !== 3'b010) begin
      bad++;
      $display("FAIL wr_no_valid got sv_valid/dp_gnt/we=%b exp=010",
               {bus.sv_valid, bus.dp_gnt, bus.mem_we});
    end
    cyc();
    bus.dp_req = 1'b0;
    bus.ld_req = 1'b1; bus.ld_wr = 1'b0; bus.ld_addr = 8'h20;
    @(negedge clk);
    total++;
    if ({bus.dp_valid, bus.dp_dout, bus.ld_gnt} !== 3'b111) begin
      bad++;
      $display("FAIL dp_readback got valid/dout/ld_gnt=%b exp=111",
               {bus.dp_valid, bus.dp_dout, bus.ld_gnt});
    end
    cyc();
    bus.ld_req = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.ld_valid, bus.ld_dout, bus.dp_valid} !== 3'b110) begin
      bad++;
      $display("FAIL ld_read got ld_valid/ld_dout/dp_valid=%b exp=110",
               {bus.ld_valid, bus.ld_dout, bus.dp_valid});
    end
    cyc();
  endtask

  task automatic test_reset_mid_sweep();
    ram[3]   = 1'b1;
    ram[200] = 1'b1;
    bus.clr_req = 1'b1;
    cyc();
    bus.clr_req = 1'b0;
    for (int i = 0; i < 100; i++) cyc();
    @(negedge clk);
    total++;
    if ({bus.clr_busy, bus.mem_addr} !== {1'b1, 8'd100}) begin
      bad++;
      $display("FAIL mid_sweep_pos got busy,addr=%b,%0d exp=1,100", bus.clr_busy, bus.mem_addr);
    end
    cyc();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.mem_en !== 1'b0) begin
      bad++;
      $display("FAIL mid_sweep_rst_en got=%b exp=0", bus.mem_en);
    end
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({bus.clr_busy, bus.clr_done, bus.mem_en} !== 3'b000) begin
        bad++;
        $display("FAIL abort cyc=%0d got busy/done/en=%b exp=000", i,
                 {bus.clr_busy, bus.clr_done, bus.mem_en});
      end
      cyc();
    end
    total++;
    if ({ram[3], ram[200]} !== 2'b01) begin
      bad++;
      $display("FAIL partial_clear got ram3/ram200=%b exp=01", {ram[3], ram[200]});
    end
    bus.clr_req = 1'b1;
    cyc();
    bus.clr_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({bus.clr_busy, bus.mem_we, bus.mem_addr} !== {2'b11, 8'(i)}) begin
        bad++;
        $display("FAIL restart cyc=%0d got busy/we,addr=%b,%0d exp=11,%0d", i,
                 {bus.clr_busy, bus.mem_we}, bus.mem_addr, i);
      end
      cyc();
    end
    do_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    ram_q = 1'b0;
    for (int i = 0; i < N_CELLS; i++) ram[i] = 1'b0;
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_clear();
    test_tie_fairness();
    test_loader_priority();
    test_read_latency();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
